// File: rtl/axi_nibble_master_pkg.sv
// Shared definitions for the nibble-bus AXI-lite-style master:
// state encoding, default channel widths and default watchdog limit.
package axi_nib_pkg;

    localparam int AXI_NIB_ADDR_W  = 4;
    localparam int AXI_NIB_WDATA_W = 4;
    localparam int AXI_NIB_RDATA_W = 8;
    localparam int AXI_NIB_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_ADDR = 2'd1,
        ST_RD_DATA = 2'd2,
        ST_WR      = 2'd3
    } axi_nib_state_t;

endpackage

// File: rtl/axi_nibble_master_if.sv
// Command/response port plus AR/R/AW/W handshake channels of the nibble bus.
// The master modport is the initiator's view; slave is the environment's view
// (command source and responder together).
interface axi_nib_if
    import axi_nib_pkg::*;
#(
    parameter int ADDR_W  = AXI_NIB_ADDR_W,
    parameter int WDATA_W = AXI_NIB_WDATA_W,
    parameter int RDATA_W = AXI_NIB_RDATA_W
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic               cmd_write;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [WDATA_W-1:0] cmd_wdata;

    logic               rsp_valid;
    logic               rsp_write;
    logic               rsp_err;
    logic [RDATA_W-1:0] rsp_rdata;

    logic               m_arvalid;
    logic [ADDR_W-1:0]  m_araddr;
    logic               s_arready;
    logic               m_rready;
    logic               s_rvalid;
    logic [RDATA_W-1:0] s_rdata;
    logic               m_awvalid;
    logic [ADDR_W-1:0]  m_awaddr;
    logic               s_awready;
    logic               m_wvalid;
    logic [WDATA_W-1:0] m_wdata;
    logic               s_wready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_write, rsp_err, rsp_rdata,
        output m_arvalid, m_araddr, input s_arready,
        output m_rready,  input s_rvalid, s_rdata,
        output m_awvalid, m_awaddr, input s_awready,
        output m_wvalid,  m_wdata,  input s_wready
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_write, rsp_err, rsp_rdata,
        input  m_arvalid, m_araddr, output s_arready,
        input  m_rready,  output s_rvalid, s_rdata,
        input  m_awvalid, m_awaddr, output s_awready,
        input  m_wvalid,  m_wdata,  output s_wready
    );

endinterface

// File: rtl/axi_nibble_master_watchdog.sv
// Phase watchdog: counts enabled cycles since the last clear and flags the
// TIMEOUT-th such cycle. The count saturates there so it never wraps.
module axi_nib_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired_o = en_i && (count_q == CW'(TIMEOUT - 1));

    // Next count: clear wins, otherwise advance until the limit is reached.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (en_i && !expired_o) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/axi_nibble_master.sv
// Single-beat initiator for the nibble register bus: turns one command into
// an AR/R read or an AW+W write and returns one response pulse per command.
// Optional watchdog: define AXI_NIB_TIMEOUT_EN to abort stalled phases.
module axi_nibble_master
    import axi_nib_pkg::*;
#(
    parameter int ADDR_W  = AXI_NIB_ADDR_W,
    parameter int WDATA_W = AXI_NIB_WDATA_W,
    parameter int RDATA_W = AXI_NIB_RDATA_W,
    parameter int TIMEOUT = AXI_NIB_TIMEOUT
) (
    input logic      clk,
    input logic      rst_n,
    axi_nib_if.master bus
);
    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("axi_nibble_master: TIMEOUT must be at least 2");
    end

    axi_nib_state_t     state_q;
    logic               cmd_ready_q;
    logic               rsp_valid_q;
    logic               rsp_write_q;
    logic [RDATA_W-1:0] rsp_rdata_q;
    logic               m_arvalid_q;
    logic [ADDR_W-1:0]  m_araddr_q;
    logic               m_rready_q;
    logic               m_awvalid_q;
    logic [ADDR_W-1:0]  m_awaddr_q;
    logic               m_wvalid_q;
    logic [WDATA_W-1:0] m_wdata_q;

    logic ar_hs, r_hs, aw_hs, w_hs;
    logic aw_done, w_done;

    assign ar_hs   = m_arvalid_q & bus.s_arready;
    assign r_hs    = m_rready_q  & bus.s_rvalid;
    assign aw_hs   = m_awvalid_q & bus.s_awready;
    assign w_hs    = m_wvalid_q  & bus.s_wready;
    // A write channel is done once its handshake has happened or happens now.
    assign aw_done = !m_awvalid_q || bus.s_awready;
    assign w_done  = !m_wvalid_q  || bus.s_wready;

`ifdef AXI_NIB_TIMEOUT_EN
    logic rsp_err_q;
    logic wd_expired;
    logic abort;

    axi_nib_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   ((state_q == ST_IDLE) || ar_hs || r_hs || aw_hs || w_hs),
        .en_i      (state_q != ST_IDLE),
        .expired_o (wd_expired)
    );

    // A handshake landing in the expiry cycle still counts as progress.
    assign abort       = wd_expired && !(ar_hs || r_hs || aw_hs || w_hs);
    assign bus.rsp_err = rsp_err_q;
`else
    assign bus.rsp_err = 1'b0;
`endif

    // Command FSM; every bus-facing output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            m_arvalid_q <= 1'b0;
            m_araddr_q  <= '0;
            m_rready_q  <= 1'b0;
            m_awvalid_q <= 1'b0;
            m_awaddr_q  <= '0;
            m_wvalid_q  <= 1'b0;
            m_wdata_q   <= '0;
`ifdef AXI_NIB_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
`ifdef AXI_NIB_TIMEOUT_EN
            if (abort) begin
                state_q     <= ST_IDLE;
                cmd_ready_q <= 1'b1;
                m_arvalid_q <= 1'b0;
                m_rready_q  <= 1'b0;
                m_awvalid_q <= 1'b0;
                m_wvalid_q  <= 1'b0;
                rsp_valid_q <= 1'b1;
                rsp_write_q <= (state_q == ST_WR);
                rsp_err_q   <= 1'b1;
                rsp_rdata_q <= '0;
            end else
`endif
            begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.cmd_valid) begin
                            cmd_ready_q <= 1'b0;
                            m_araddr_q  <= bus.cmd_addr;
                            m_awaddr_q  <= bus.cmd_addr;
                            m_wdata_q   <= bus.cmd_wdata;
                            if (bus.cmd_write) begin
                                m_awvalid_q <= 1'b1;
                                m_wvalid_q  <= 1'b1;
                                state_q     <= ST_WR;
                            end else begin
                                m_arvalid_q <= 1'b1;
                                state_q     <= ST_RD_ADDR;
                            end
                        end
                    end
                    ST_RD_ADDR: begin
                        if (ar_hs) begin
                            m_arvalid_q <= 1'b0;
                            m_rready_q  <= 1'b1;
                            state_q     <= ST_RD_DATA;
                        end
                    end
                    ST_RD_DATA: begin
                        if (r_hs) begin
                            m_rready_q  <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            rsp_write_q <= 1'b0;
                            rsp_rdata_q <= bus.s_rdata;
`ifdef AXI_NIB_TIMEOUT_EN
                            rsp_err_q   <= 1'b0;
`endif
                            state_q     <= ST_IDLE;
                        end
                    end
                    ST_WR: begin
                        if (aw_done && w_done) begin
                            m_awvalid_q <= 1'b0;
                            m_wvalid_q  <= 1'b0;
                            cmd_ready_q <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            rsp_write_q <= 1'b1;
                            rsp_rdata_q <= '0;
`ifdef AXI_NIB_TIMEOUT_EN
                            rsp_err_q   <= 1'b0;
`endif
                            state_q     <= ST_IDLE;
                        end else begin
                            if (aw_hs) m_awvalid_q <= 1'b0;
                            if (w_hs)  m_wvalid_q  <= 1'b0;
                        end
                    end
                    default: begin
                        state_q     <= ST_IDLE;
                        cmd_ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.m_arvalid = m_arvalid_q;
    assign bus.m_araddr  = m_araddr_q;
    assign bus.m_rready  = m_rready_q;
    assign bus.m_awvalid = m_awvalid_q;
    assign bus.m_awaddr  = m_awaddr_q;
    assign bus.m_wvalid  = m_wvalid_q;
    assign bus.m_wdata   = m_wdata_q;

endmodule

// File: tb/tb_axi_nibble_master.sv
// Bench for axi_nibble_master. Each scenario is a cycle-indexed table of
// command/responder inputs; a transaction-level planner turns the table into
// per-cycle expected outputs, which are compared against the DUT every cycle.
module tb_axi_nibble_master;
    import axi_nib_pkg::*;

    localparam int AW   = 4;
    localparam int WW   = 4;
    localparam int RW   = 8;
    localparam int TO   = 16;
    localparam int MAXC = 128;
`ifdef AXI_NIB_TIMEOUT_EN
    localparam bit WD_ON = 1'b1;
`else
    localparam bit WD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axi_nib_if #(.ADDR_W(AW), .WDATA_W(WW), .RDATA_W(RW)) bus ();

    axi_nibble_master #(
        .ADDR_W(AW), .WDATA_W(WW), .RDATA_W(RW), .TIMEOUT(TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // stimulus tables
    logic          i_cv [MAXC];
    logic          i_cw [MAXC];
    logic [AW-1:0] i_ca [MAXC];
    logic [WW-1:0] i_cd [MAXC];
    logic          i_arr[MAXC];
    logic          i_rv [MAXC];
    logic [RW-1:0] i_rd [MAXC];
    logic          i_awr[MAXC];
    logic          i_wr [MAXC];

    // expected outputs
    logic          e_cr [MAXC];
    logic          e_arv[MAXC];
    logic [AW-1:0] e_ara[MAXC];
    logic          e_rr [MAXC];
    logic          e_awv[MAXC];
    logic [AW-1:0] e_awa[MAXC];
    logic          e_wv [MAXC];
    logic [WW-1:0] e_wd [MAXC];
    logic          e_rsp[MAXC];
    logic          e_rw [MAXC];
    logic          e_err[MAXC];
    logic [RW-1:0] e_rd [MAXC];

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, c, act, exp);
        end
    endtask

    task automatic clear_all();
        for (int c = 0; c < MAXC; c++) begin
            i_cv[c] = 0; i_cw[c] = 0; i_ca[c] = '0; i_cd[c] = '0;
            i_arr[c] = 0; i_rv[c] = 0; i_awr[c] = 0; i_wr[c] = 0;
            i_rd[c] = 8'(8'h30 + c);
            e_cr[c] = 1; e_arv[c] = 0; e_ara[c] = '0; e_rr[c] = 0;
            e_awv[c] = 0; e_awa[c] = '0; e_wv[c] = 0; e_wd[c] = '0;
            e_rsp[c] = 0; e_rw[c] = 0; e_err[c] = 0; e_rd[c] = '0;
        end
    endtask

    // first cycle at or after 'from' where the chosen responder ready is high
    function automatic int first_hi(input int sel, input int from, input int L);
        for (int k = from; k < L; k++) begin
            case (sel)
                0: if (i_arr[k]) return k;
                1: if (i_rv[k])  return k;
                2: if (i_awr[k]) return k;
                default: if (i_wr[k]) return k;
            endcase
        end
        return L;
    endfunction

    // mark an output as expected-high over cycles lo..hi of command accepted in c
    task automatic fill(input int sel, input int lo, input int hi, input int L, input int c);
        for (int k = lo; k <= hi && k < L; k++) begin
            case (sel)
                0: begin e_arv[k] = 1; e_ara[k] = i_ca[c]; end
                1: e_rr[k] = 1;
                2: begin e_awv[k] = 1; e_awa[k] = i_ca[c]; end
                3: begin e_wv[k] = 1; e_wd[k] = i_cd[c]; end
                default: e_cr[k] = 0;
            endcase
        end
    endtask

    // transaction-level model: walk commands, derive each one's timeline
    task automatic plan(input int L);
        int c, s, a, r, w, h1, h2, rsp;
        logic err;
        logic [RW-1:0] rd;
        c = 0;
        while (c < L) begin
            if (!i_cv[c]) begin
                c++;
                continue;
            end
            s = c + 1; rsp = L; err = 0; rd = '0;
            if (!i_cw[c]) begin
                a = first_hi(0, s, L);
                if (WD_ON && a >= s + TO) begin
                    fill(0, s, s + TO - 1, L, c); rsp = s + TO; err = 1;
                end else begin
                    fill(0, s, a, L, c);
                    if (a < L) begin
                        r = first_hi(1, a + 1, L);
                        if (WD_ON && r >= a + 1 + TO) begin
                            fill(1, a + 1, a + TO, L, c); rsp = a + 1 + TO; err = 1;
                        end else begin
                            fill(1, a + 1, r, L, c);
                            rsp = r + 1;
                            if (r < L) rd = i_rd[r];
                        end
                    end
                end
            end else begin
                a  = first_hi(2, s, L);
                w  = first_hi(3, s, L);
                h1 = (a < w) ? a : w;
                h2 = (a < w) ? w : a;
                if (WD_ON && h1 >= s + TO) begin
                    fill(2, s, s + TO - 1, L, c); fill(3, s, s + TO - 1, L, c);
                    rsp = s + TO; err = 1;
                end else if (WD_ON && a != w && h2 >= h1 + 1 + TO) begin
                    fill(2, s, (a == h1) ? a : h1 + TO, L, c);
                    fill(3, s, (w == h1) ? w : h1 + TO, L, c);
                    rsp = h1 + 1 + TO; err = 1;
                end else begin
                    fill(2, s, a, L, c); fill(3, s, w, L, c);
                    rsp = h2 + 1;
                end
            end
            fill(4, s, rsp - 1, L, c);
            if (rsp < L) begin
                e_rsp[rsp] = 1; e_rw[rsp] = i_cw[c]; e_err[rsp] = err;
                e_rd[rsp]  = err ? '0 : rd;
            end
            c = (rsp > c) ? rsp : c + 1;
        end
    endtask

    task automatic drive(input int c);
        bus.cmd_valid = i_cv[c]; bus.cmd_write = i_cw[c];
        bus.cmd_addr  = i_ca[c]; bus.cmd_wdata = i_cd[c];
        bus.s_arready = i_arr[c]; bus.s_rvalid = i_rv[c]; bus.s_rdata = i_rd[c];
        bus.s_awready = i_awr[c]; bus.s_wready = i_wr[c];
    endtask

    task automatic drive_idle();
        bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
        bus.s_arready = 0; bus.s_rvalid = 0; bus.s_rdata = '0;
        bus.s_awready = 0; bus.s_wready = 0;
    endtask

    task automatic compare(input int c);
        chk("cmd_ready", c, bus.cmd_ready, e_cr[c]);
        chk("m_arvalid", c, bus.m_arvalid, e_arv[c]);
        chk("m_rready",  c, bus.m_rready,  e_rr[c]);
        chk("m_awvalid", c, bus.m_awvalid, e_awv[c]);
        chk("m_wvalid",  c, bus.m_wvalid,  e_wv[c]);
        chk("rsp_valid", c, bus.rsp_valid, e_rsp[c]);
        if (e_arv[c]) chk("m_araddr", c, bus.m_araddr, e_ara[c]);
        if (e_awv[c]) chk("m_awaddr", c, bus.m_awaddr, e_awa[c]);
        if (e_wv[c])  chk("m_wdata",  c, bus.m_wdata,  e_wd[c]);
        if (e_rsp[c]) begin
            chk("rsp_err",   c, bus.rsp_err,   e_err[c]);
            chk("rsp_rdata", c, bus.rsp_rdata, e_rd[c]);
            if (!e_err[c]) chk("rsp_write", c, bus.rsp_write, e_rw[c]);
        end
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // cycle c spans posedge c .. posedge c+1; inputs of c are sampled at c+1
    task automatic run(input int L);
        do_reset();
        for (int c = 0; c < L; c++) begin
            drive(c);
            compare(c);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive_idle();

        // read, responder always ready
        clear_all();
        i_cv[2] = 1; i_ca[2] = 4'h3;
        for (int c = 0; c < MAXC; c++) begin
            i_arr[c] = 1; i_rv[c] = 1; i_rd[c] = 8'hA5;
        end
        plan(20);
        chk("model_rd_rsp",   5, e_rsp[5], 1);
        chk("model_rd_rdata", 5, e_rd[5], 8'hA5);
        chk("model_rd_rready", 4, e_rr[4], 1);
        run(20);

        // write, address ready early, data ready late
        clear_all();
        i_cv[2] = 1; i_cw[2] = 1; i_ca[2] = 4'h5; i_cd[2] = 4'hC;
        i_awr[3] = 1; i_wr[6] = 1;
        plan(20);
        chk("model_wr_rsp",  7, e_rsp[7], 1);
        chk("model_wr_awv4", 4, e_awv[4], 0);
        chk("model_wr_wv6",  6, e_wv[6], 1);
        run(20);

        // back-to-back reads with cmd_valid held
        clear_all();
        for (int c = 2; c <= 5; c++) begin
            i_cv[c] = 1; i_ca[c] = 4'h1;
        end
        i_ca[5] = 4'h2;
        for (int c = 0; c < MAXC; c++) begin
            i_arr[c] = 1; i_rv[c] = 1;
        end
        plan(20);
        chk("model_b2b_rdata", 5, e_rd[5], 8'h34);
        chk("model_b2b_ar",    6, e_arv[6], 1);
        chk("model_b2b_addr",  6, e_ara[6], 4'h2);
        run(20);

        // commands ignored while a write is pending; both readies together
        clear_all();
        i_cv[2] = 1; i_cw[2] = 1; i_ca[2] = 4'h5; i_cd[2] = 4'h9;
        i_cv[4] = 1; i_ca[4] = 4'hE;
        i_cv[6] = 1; i_cw[6] = 1; i_ca[6] = 4'hE; i_cd[6] = 4'h1;
        i_awr[8] = 1; i_wr[8] = 1;
        plan(20);
        chk("model_busy_rsp", 9, e_rsp[9], 1);
        chk("model_busy_addr", 5, e_awa[5], 4'h5);
        run(20);

        // data ready before address; then a slow read
        clear_all();
        i_cv[1] = 1; i_cw[1] = 1; i_ca[1] = 4'hF; i_cd[1] = 4'h1;
        i_wr[3] = 1; i_awr[5] = 1;
        i_cv[10] = 1; i_ca[10] = 4'hA;
        i_arr[14] = 1; i_rv[20] = 1;
        plan(30);
        chk("model_slow_wr", 6, e_rsp[6], 1);
        chk("model_slow_rd", 21, e_rd[21], 8'h44);
        run(30);

        // read address never accepted
        clear_all();
        i_cv[2] = 1; i_ca[2] = 4'h7;
        plan(110);
`ifdef AXI_NIB_TIMEOUT_EN
        chk("model_wd_err",  19, e_err[19], 1);
        chk("model_wd_drop", 19, e_arv[19], 0);
`else
        chk("model_nowd_ar", 103, e_arv[103], 1);
`endif
        run(110);

        // write data never accepted after address handshake
        clear_all();
        i_cv[2] = 1; i_cw[2] = 1; i_ca[2] = 4'hA; i_cd[2] = 4'h3;
        i_awr[4] = 1;
        plan(60);
`ifdef AXI_NIB_TIMEOUT_EN
        chk("model_wd_wr", 21, e_rsp[21], 1);
`else
        chk("model_nowd_wv", 40, e_wv[40], 1);
`endif
        run(60);

        // asynchronous reset while waiting for read data
        clear_all();
        i_cv[2] = 1; i_ca[2] = 4'h6;
        for (int c = 0; c < MAXC; c++) i_arr[c] = 1;
        plan(10);
        do_reset();
        for (int c = 0; c <= 6; c++) begin
            drive(c);
            compare(c);
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_rready",   7, bus.m_rready, 0);
        chk("rst_cmdready", 7, bus.cmd_ready, 1);
        chk("rst_arvalid",  7, bus.m_arvalid, 0);
        chk("rst_rsp",      7, bus.rsp_valid, 0);
        drive_idle();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            chk("post_rst_rsp",   8 + k, bus.rsp_valid, 0);
            chk("post_rst_ready", 8 + k, bus.cmd_ready, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
